// File: rtl/vram_arbiter.sv
// Video RAM arbiter: display fetch has absolute priority, two clients share leftover
// cycles round-robin, client-1 writes are held off until vertical blanking.
module vram_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int STARVE_CYC = 1023
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vblank,
  input  logic              new_frame,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rvalid,
  input  logic              c0_req,
  input  logic              c1_req,
  input  logic              c0_we,
  input  logic              c1_we,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [DATA_W-1:0] c0_wdata,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c0_gnt,
  output logic              c1_gnt,
  output logic              c0_rvalid,
  output logic              c1_rvalid,
  output logic              c0_starve,
  output logic              c1_starve,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_CYC + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_CYC);

  typedef enum logic [1:0] {OWN_NONE, OWN_DISP, OWN_C0, OWN_C1} owner_e;

  owner_e           owner_q, owner_d;
  logic             rr_last_q, rr_last_d;   // 1: client 1 was granted last
  logic [CNT_W-1:0] wait0_q, wait0_d, wait1_q, wait1_d;
  logic             starve0_q, starve0_d, starve1_q, starve1_d;
  logic             elig0, elig1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_q   <= OWN_NONE;
      rr_last_q <= 1'b1;
      wait0_q   <= '0;
      wait1_q   <= '0;
      starve0_q <= 1'b0;
      starve1_q <= 1'b0;
    end else begin
      owner_q   <= owner_d;
      rr_last_q <= rr_last_d;
      wait0_q   <= wait0_d;
      wait1_q   <= wait1_d;
      starve0_q <= starve0_d;
      starve1_q <= starve1_d;
    end
  end

  // Grants are qualified with reset_n so every output is quiet while reset is held.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    c0_gnt    = 1'b0;
    c1_gnt    = 1'b0;
    owner_d   = OWN_NONE;
    rr_last_d = rr_last_q;
    elig0     = c0_req;
    elig1     = c1_req && (!c1_we || vblank);
    if (!reset_n) begin
      owner_d = OWN_NONE;
    end else if (disp_req) begin
      mem_en   = 1'b1;
      mem_addr = disp_addr;
      owner_d  = OWN_DISP;
    end else if (elig0 && (!elig1 || rr_last_q)) begin
      mem_en    = 1'b1;
      mem_we    = c0_we;
      mem_addr  = c0_addr;
      mem_wdata = c0_wdata;
      c0_gnt    = 1'b1;
      rr_last_d = 1'b0;
      owner_d   = c0_we ? OWN_NONE : OWN_C0;
    end else if (elig1) begin
      mem_en    = 1'b1;
      mem_we    = c1_we;
      mem_addr  = c1_addr;
      mem_wdata = c1_wdata;
      c1_gnt    = 1'b1;
      rr_last_d = 1'b1;
      owner_d   = c1_we ? OWN_NONE : OWN_C1;
    end
  end

  // Flags set only on the edge where a counter first reaches the limit.
  always_comb begin
    wait0_d = wait0_q;
    wait1_d = wait1_q;
    if (!c0_req || c0_gnt)  wait0_d = '0;
    else if (wait0_q != LIM) wait0_d = wait0_q + CNT_W'(1);
    if (!c1_req || c1_gnt)  wait1_d = '0;
    else if (wait1_q != LIM) wait1_d = wait1_q + CNT_W'(1);
    starve0_d = new_frame ? 1'b0 : (starve0_q || (wait0_d == LIM && wait0_q != LIM));
    starve1_d = new_frame ? 1'b0 : (starve1_q || (wait1_d == LIM && wait1_q != LIM));
  end

  assign disp_rvalid = (owner_q == OWN_DISP);
  assign c0_rvalid   = (owner_q == OWN_C0);
  assign c1_rvalid   = (owner_q == OWN_C1);
  assign rdata       = (owner_q != OWN_NONE) ? mem_rdata : '0;
  assign c0_starve   = starve0_q;
  assign c1_starve   = starve1_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus queues expected grant/read-return events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_vram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vblank, new_frame, disp_req;
  logic [14:0] disp_addr, c0_addr, c1_addr, mem_addr;
  logic        disp_rvalid;
  logic        c0_req, c1_req, c0_we, c1_we;
  logic [7:0]  c0_wdata, c1_wdata, rdata, mem_wdata, mem_rdata;
  logic        c0_gnt, c1_gnt, c0_rvalid, c1_rvalid, c0_starve, c1_starve;
  logic        mem_en, mem_we;

  vram_arbiter #(.ADDR_W(15), .DATA_W(8), .STARVE_CYC(8)) dut (
    .clk(clk), .reset_n(reset_n), .vblank(vblank), .new_frame(new_frame),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rvalid(disp_rvalid),
    .c0_req(c0_req), .c1_req(c1_req), .c0_we(c0_we), .c1_we(c1_we),
    .c0_addr(c0_addr), .c1_addr(c1_addr), .c0_wdata(c0_wdata), .c1_wdata(c1_wdata),
    .c0_gnt(c0_gnt), .c1_gnt(c1_gnt), .c0_rvalid(c0_rvalid), .c1_rvalid(c1_rvalid),
    .c0_starve(c0_starve), .c1_starve(c1_starve), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM, preloaded with a known pattern.
  logic [7:0] ram [0:32767];
  initial for (int i = 0; i < 32768; i++) ram[i] = 8'(i) ^ 8'h5A;
  initial mem_rdata = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  function automatic logic [7:0] pat(input logic [14:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  typedef enum int {EV_G0, EV_G1, EV_RVD, EV_RV0, EV_RV1} ev_e;
  typedef struct {
    ev_e         kind;
    logic        we;
    logic [14:0] addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  function automatic void push(input ev_e k, input logic we, input logic [14:0] a,
                               input logic [7:0] d);
    exp_t e;
    e.kind = k; e.we = we; e.addr = a; e.data = d;
    sb.push_back(e);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic observe(input ev_e k);
    exp_t        e;
    logic [23:0] act, exp;
    n_vec++;
    if (k == EV_G0 || k == EV_G1) act = {mem_we, mem_addr, mem_wdata};
    else                          act = {16'h0, rdata};
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: got %h expected no event (t=%0t)", k.name(), act, $time);
    end else begin
      e = sb.pop_front();
      if (k == EV_G0 || k == EV_G1) exp = {e.we, e.addr, e.data};
      else                          exp = {16'h0, e.data};
      if (e.kind != k || act !== exp) begin
        n_err++;
        $display("FAIL event: got %s %h expected %s %h (t=%0t)",
                 k.name(), act, e.kind.name(), exp, $time);
      end
    end
  endtask

  // Fixed per-cycle order: read returns first, then grants.
  always @(negedge clk) begin
    if (disp_rvalid) observe(EV_RVD);
    if (c0_rvalid)   observe(EV_RV0);
    if (c1_rvalid)   observe(EV_RV1);
    if (c0_gnt)      observe(EV_G0);
    if (c1_gnt)      observe(EV_G1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string nm);
    check(nm, {23'h0, mem_en, mem_we, c0_gnt, c1_gnt, disp_rvalid, c0_rvalid, c1_rvalid,
               c0_starve, c1_starve}, 32'h0);
    check({nm, "_bus"}, {mem_addr, mem_wdata, rdata}, 32'h0);
  endtask

  initial begin
    reset_n = 1'b0; vblank = 1'b0; new_frame = 1'b0;
    disp_req = 1'b0; disp_addr = '0;
    c0_req = 1'b1; c0_we = 1'b0; c0_addr = 15'h0100; c0_wdata = '0;
    c1_req = 1'b0; c1_we = 1'b0; c1_addr = 15'h0200; c1_wdata = '0;
    repeat (2) tick();
    check_quiet("reset_state");

    // Round-robin after reset: c0 wins the first tie.
    reset_n = 1'b1; vblank = 1'b1; c1_req = 1'b1;
    push(EV_G0, 0, 15'h0100, 0); push(EV_RV0, 0, 0, pat(15'h0100));
    push(EV_G1, 0, 15'h0200, 0); push(EV_RV1, 0, 0, pat(15'h0200));
    push(EV_G0, 0, 15'h0100, 0); push(EV_RV0, 0, 0, pat(15'h0100));
    push(EV_G1, 0, 15'h0200, 0); push(EV_RV1, 0, 0, pat(15'h0200));
    repeat (4) tick();
    c0_req = 1'b0; c1_req = 1'b0;
    repeat (2) tick();

    // Display priority for 20 cycles, c0 starving meanwhile.
    disp_req = 1'b1; c0_req = 1'b1; c0_addr = 15'h0300;
    for (int i = 0; i < 20; i++) begin
      disp_addr = 15'h0040 + 15'(i);
      push(EV_RVD, 0, 0, pat(disp_addr));
      tick();
      if (i == 6) check("starve_before_limit", {31'h0, c0_starve}, 32'h0);
      if (i == 7) check("starve_at_limit", {31'h0, c0_starve}, 32'h1);
    end
    disp_req = 1'b0;
    push(EV_G0, 0, 15'h0300, 0); push(EV_RV0, 0, 0, pat(15'h0300));
    tick();
    c0_req = 1'b0;
    check("starve_sticky", {30'h0, c0_starve, c1_starve}, 32'h2);
    tick();
    new_frame = 1'b1;
    tick();
    new_frame = 1'b0;
    check("starve_cleared", {30'h0, c0_starve, c1_starve}, 32'h0);

    // Client-1 write held off outside vblank, granted as soon as vblank rises.
    vblank = 1'b0; c1_req = 1'b1; c1_we = 1'b1; c1_addr = 15'h0123; c1_wdata = 8'h3C;
    repeat (5) tick();
    check("c1_write_gated", {30'h0, c1_gnt, mem_en}, 32'h0);
    vblank = 1'b1;
    push(EV_G1, 1, 15'h0123, 8'h3C);
    tick();
    c1_req = 1'b0; c1_we = 1'b0; c1_wdata = '0; vblank = 1'b0;
    tick();
    c1_req = 1'b1;
    push(EV_G1, 0, 15'h0123, 0); push(EV_RV1, 0, 0, 8'h3C);
    tick();
    c1_req = 1'b0;
    repeat (2) tick();

    // Client-0 write then read-back of the same address.
    c0_req = 1'b1; c0_we = 1'b1; c0_addr = 15'h0010; c0_wdata = 8'hA5;
    push(EV_G0, 1, 15'h0010, 8'hA5);
    tick();
    c0_we = 1'b0; c0_wdata = '0;
    push(EV_G0, 0, 15'h0010, 0); push(EV_RV0, 0, 0, 8'hA5);
    tick();
    c0_req = 1'b0;
    repeat (2) tick();

    // Reset right after a read grant: the pending return is dropped and rr_last resets.
    c0_req = 1'b1; c0_addr = 15'h0050;
    push(EV_G0, 0, 15'h0050, 0);
    tick();
    reset_n = 1'b0; c1_req = 1'b1; c1_addr = 15'h0060;
    #1;
    check_quiet("mid_reset");
    tick();
    check_quiet("mid_reset_held");
    reset_n = 1'b1;
    push(EV_G0, 0, 15'h0050, 0); push(EV_RV0, 0, 0, pat(15'h0050));
    push(EV_G1, 0, 15'h0060, 0); push(EV_RV1, 0, 0, pat(15'h0060));
    repeat (2) tick();
    c0_req = 1'b0; c1_req = 1'b0;
    repeat (3) tick();

    check("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
Shares one single-port synchronous video RAM (1-cycle read latency) among three requesters: the display pixel fetch, CPU port (client 0) and game logic port (client 1). The display fetch has absolute priority; clients share the remaining cycles round-robin. Client 1 writes are gated to vertical blanking for tear-free updates. The block sits between vga_controller/graphics_gen and the video RAM, alongside game_fsm.

Parameters:
ADDR_W, 15, RAM address width
DATA_W, 8, RAM data width
STARVE_CYC, 1023, client wait cycles (per request) after which the starve flag sets

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
vblank  in  1  high during vertical blanking (from vga_controller timing)
new_frame  in  1  one-cycle pulse at frame start; clears starve flags
disp_req  in  1  display fetch request, level, one access per cycle
disp_addr  in  ADDR_W  display read address
disp_rvalid  out  1  display read data valid
c0_req, c1_req  in  1 each  client request, held until grant
c0_we, c1_we  in  1 each  write enable, held with req
c0_addr, c1_addr  in  ADDR_W each  client address, held with req
c0_wdata, c1_wdata  in  DATA_W each  client write data, held with req
c0_gnt, c1_gnt  out  1 each  one-cycle accept pulse
c0_rvalid, c1_rvalid  out  1 each  client read data valid
c0_starve, c1_starve  out  1 each  sticky starvation flag
rdata  out  DATA_W  shared read data, qualified by the *_rvalid strobes
mem_en  out  1  RAM enable
mem_we  out  1  RAM write enable
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_rdata  in  DATA_W  RAM read data, valid one cycle after a read with mem_en

Behaviour:
- Reset (async assert, sync release): all outputs 0; rr_last = client 1 (so client 0 wins first tie); wait counters 0; starve flags 0; owner pipe = none.
- Arbitration is combinational each cycle from current inputs; mem_* driven combinationally from the winner; c*_gnt combinational, same cycle as mem_en.
- Priority: disp_req=1 -> display wins, mem_en=1, mem_we=0, mem_addr=disp_addr, no client gnt.
- Else eligible clients: c0 if c0_req; c1 if c1_req && (!c1_we || vblank). Client-1 reads are never vblank-gated.
- One eligible: it wins. Both: the client not equal to rr_last wins. rr_last updates to the winner on every client grant.
- Winner client: mem_en=1, mem_we=cN_we, mem_addr=cN_addr, mem_wdata=cN_wdata, cN_gnt=1 for that cycle. Client may change/drop req the cycle after gnt; holding req issues a new request (back-to-back grants allowed).
- Nothing eligible: mem_en=0, mem_we=0, mem_addr/mem_wdata = 0.
- Read return: registered owner tag (disp/c0/c1/none) for non-write accesses; next cycle exactly one of disp_rvalid/c0_rvalid/c1_rvalid =1, and rdata = mem_rdata (pass-through). Writes produce no rvalid.
- Wait counters: per client, clear on gnt or when req=0; increment (saturating at STARVE_CYC) each cycle req=1 without gnt. Counter reaching STARVE_CYC sets cN_starve; flag stays set until new_frame (new_frame wins over a same-cycle set).
- Counter width = clog2(STARVE_CYC+1).
- Reset mid-access: pending rvalid is discarded; no strobes after reset release until a new grant.
- Clients must not change addr/we/wdata while req=1 and ungranted; behaviour otherwise is undefined (sampled value at grant is used).

Test Plan:
- Reset: assert reset_n=0 mid-stream -> all outputs 0 immediately; after release with c0_req=c1_req=1 (reads), first grant is c0.
- Display priority: disp_req=1 continuously for 20 cycles with c0_req=1 -> c0_gnt=0 throughout, disp_rvalid=1 from cycle 2 to 21; c0_gnt=1 on first cycle disp_req=0.
- Round-robin: c0,c1 both hold read req, disp_req=0, vblank=1 -> grants alternate c0,c1,c0,c1; rvalid strobes follow one cycle later with rdata=mem_rdata.
- Vblank gating: vblank=0, c1_req=1 c1_we=1, c0 idle -> no c1_gnt; raise vblank -> c1_gnt same cycle, mem_we=1, mem_addr=c1_addr, mem_wdata=c1_wdata, no c1_rvalid.
- Starvation: STARVE_CYC=8, disp_req=1 and c0_req=1 for 10 cycles -> c0_starve=1 from the cycle counter hits 8; stays 1 after grant; clears on new_frame pulse.
- Read/write mix: c0 write at addr 0x0010 data 0xA5 then c0 read 0x0010 back-to-back -> c0_rvalid=1 once, one cycle after read grant, rdata=0xA5 from RAM model.
